// File: rtl/pkt_queue_merge.sv
// Merges four packet-cache AXIS queues into one stream, ordered by a FIFO of one-hot queue tags.

// Tag FIFO: first-word-fall-through store for queue-select tags.
// Latency: a pushed tag is visible at the head on the cycle after the push.
// Backpressure: full blocks pushes; space freed by a pop is usable from the next cycle.
module pkt_tag_fifo #(
    parameter int W  = 4,
    parameter int DB = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] wr_dat,
    input  logic         pop,
    output logic [W-1:0] rd_dat,
    output logic         empty,
    output logic         full
);
    localparam int DEPTH = 1 << DB;

    logic [W-1:0]  mem [DEPTH];
    logic [DB-1:0] wr_ptr;
    logic [DB-1:0] rd_ptr;
    logic [DB:0]   count;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (DB+1)'(DEPTH));
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign rd_dat  = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wr_dat;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + DB'(1);
            if (do_pop)  rd_ptr <= rd_ptr + DB'(1);
            if (do_push && !do_pop)      count <= count + (DB+1)'(1);
            else if (!do_push && do_pop) count <= count - (DB+1)'(1);
        end
    end
endmodule

// Queue merge: pops a tag in IDLE, then passes the tagged queue straight through until tlast.
// Latency: zero-cycle combinational data path while forwarding; one IDLE cycle between packets.
// Backpressure: m_axis_tready is routed only to the selected queue; all other queues see ready low.
module pkt_queue_merge #(
    parameter int C_S_AXIS_DATA_WIDTH  = 256,
    parameter int C_S_AXIS_TUSER_WIDTH = 128,
    parameter int C_TAG_DEPTH_BITS     = 4
) (
    input  logic                                axis_clk,
    input  logic                                aresetn,
    input  logic [3:0]                          qsel_in,
    input  logic                                qsel_valid,
    output logic                                qsel_ready,
    input  logic [C_S_AXIS_DATA_WIDTH-1:0]      s_axis_tdata_0,
    input  logic [C_S_AXIS_TUSER_WIDTH-1:0]     s_axis_tuser_0,
    input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]    s_axis_tkeep_0,
    input  logic                                s_axis_tlast_0,
    input  logic                                s_axis_tvalid_0,
    output logic                                s_axis_tready_0,
    input  logic [C_S_AXIS_DATA_WIDTH-1:0]      s_axis_tdata_1,
    input  logic [C_S_AXIS_TUSER_WIDTH-1:0]     s_axis_tuser_1,
    input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]    s_axis_tkeep_1,
    input  logic                                s_axis_tlast_1,
    input  logic                                s_axis_tvalid_1,
    output logic                                s_axis_tready_1,
    input  logic [C_S_AXIS_DATA_WIDTH-1:0]      s_axis_tdata_2,
    input  logic [C_S_AXIS_TUSER_WIDTH-1:0]     s_axis_tuser_2,
    input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]    s_axis_tkeep_2,
    input  logic                                s_axis_tlast_2,
    input  logic                                s_axis_tvalid_2,
    output logic                                s_axis_tready_2,
    input  logic [C_S_AXIS_DATA_WIDTH-1:0]      s_axis_tdata_3,
    input  logic [C_S_AXIS_TUSER_WIDTH-1:0]     s_axis_tuser_3,
    input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]    s_axis_tkeep_3,
    input  logic                                s_axis_tlast_3,
    input  logic                                s_axis_tvalid_3,
    output logic                                s_axis_tready_3,
    output logic [C_S_AXIS_DATA_WIDTH-1:0]      m_axis_tdata,
    output logic [C_S_AXIS_TUSER_WIDTH-1:0]     m_axis_tuser,
    output logic [C_S_AXIS_DATA_WIDTH/8-1:0]    m_axis_tkeep,
    output logic                                m_axis_tlast,
    output logic                                m_axis_tvalid,
    input  logic                                m_axis_tready,
    output logic [31:0]                         pkt_cnt,
    output logic                                tag_err
);
    localparam int DW = C_S_AXIS_DATA_WIDTH;
    localparam int UW = C_S_AXIS_TUSER_WIDTH;
    localparam int KW = C_S_AXIS_DATA_WIDTH / 8;

    typedef enum logic {IDLE, FORWARD} state_t;

    state_t        state, state_nxt;
    logic [1:0]    cur_q, cur_q_nxt;
    logic          init_done;
    logic          tag_push, tag_pop, set_err;
    logic          fifo_empty, fifo_full;
    logic [3:0]    head_tag;
    logic [1:0]    head_idx;
    logic          tag_onehot;
    logic          pkt_done;
    logic [DW-1:0] s_tdata [4];
    logic [UW-1:0] s_tuser [4];
    logic [KW-1:0] s_tkeep [4];
    logic [3:0]    s_tlast, s_tvalid, s_tready;

    assign s_tdata  = '{s_axis_tdata_0, s_axis_tdata_1, s_axis_tdata_2, s_axis_tdata_3};
    assign s_tuser  = '{s_axis_tuser_0, s_axis_tuser_1, s_axis_tuser_2, s_axis_tuser_3};
    assign s_tkeep  = '{s_axis_tkeep_0, s_axis_tkeep_1, s_axis_tkeep_2, s_axis_tkeep_3};
    assign s_tlast  = {s_axis_tlast_3, s_axis_tlast_2, s_axis_tlast_1, s_axis_tlast_0};
    assign s_tvalid = {s_axis_tvalid_3, s_axis_tvalid_2, s_axis_tvalid_1, s_axis_tvalid_0};

    // init_done holds qsel_ready low until the first clock after reset release
    assign qsel_ready = init_done & ~fifo_full;
    assign tag_push   = qsel_valid & qsel_ready;

    pkt_tag_fifo #(.W(4), .DB(C_TAG_DEPTH_BITS)) u_tag_fifo (
        .clk    (axis_clk),
        .rst_n  (aresetn),
        .push   (tag_push),
        .wr_dat (qsel_in),
        .pop    (tag_pop),
        .rd_dat (head_tag),
        .empty  (fifo_empty),
        .full   (fifo_full)
    );

    assign tag_onehot = (head_tag != 4'd0) && ((head_tag & (head_tag - 4'd1)) == 4'd0);

    always_comb begin
        head_idx = 2'd0;
        case (head_tag)
            4'b0010: head_idx = 2'd1;
            4'b0100: head_idx = 2'd2;
            4'b1000: head_idx = 2'd3;
            default: head_idx = 2'd0;
        endcase
    end

    assign m_axis_tdata  = s_tdata[cur_q];
    assign m_axis_tuser  = s_tuser[cur_q];
    assign m_axis_tkeep  = s_tkeep[cur_q];
    assign m_axis_tlast  = s_tlast[cur_q];
    assign m_axis_tvalid = (state == FORWARD) & s_tvalid[cur_q];
    assign s_tready      = (state == FORWARD) ? ((4'b0001 << cur_q) & {4{m_axis_tready}}) : 4'b0000;
    assign pkt_done      = m_axis_tvalid & m_axis_tready & m_axis_tlast;

    assign s_axis_tready_0 = s_tready[0];
    assign s_axis_tready_1 = s_tready[1];
    assign s_axis_tready_2 = s_tready[2];
    assign s_axis_tready_3 = s_tready[3];

    always_comb begin
        state_nxt = state;
        cur_q_nxt = cur_q;
        tag_pop   = 1'b0;
        set_err   = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    tag_pop = 1'b1;
                    if (tag_onehot) begin
                        cur_q_nxt = head_idx;
                        state_nxt = FORWARD;
                    end else begin
                        set_err = 1'b1;
                    end
                end
            end
            FORWARD: begin
                if (pkt_done) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge axis_clk or negedge aresetn) begin
        if (!aresetn) begin
            state     <= IDLE;
            cur_q     <= 2'd0;
            pkt_cnt   <= 32'd0;
            tag_err   <= 1'b0;
            init_done <= 1'b0;
        end else begin
            state     <= state_nxt;
            cur_q     <= cur_q_nxt;
            init_done <= 1'b1;
            if (pkt_done) pkt_cnt <= pkt_cnt + 32'd1;
            if (set_err)  tag_err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_pkt_queue_merge.sv
// Bench for pkt_queue_merge: directed tag/packet scenarios checked against a tag-order queue model.
module tb_pkt_queue_merge;
    localparam int DW = 64;
    localparam int UW = 16;
    localparam int KW = DW / 8;
    localparam int SRC_DEPTH = 128;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [UW-1:0] user;
        logic [KW-1:0] keep;
        logic          last;
    } beat_t;

    logic          axis_clk = 1'b0;
    logic          aresetn  = 1'b1;
    logic [3:0]    qsel_in;
    logic          qsel_valid;
    logic          qsel_ready;
    logic [DW-1:0] s_tdata [4];
    logic [UW-1:0] s_tuser [4];
    logic [KW-1:0] s_tkeep [4];
    logic [3:0]    s_tlast, s_tvalid, s_tready;
    logic [DW-1:0] m_tdata;
    logic [UW-1:0] m_tuser;
    logic [KW-1:0] m_tkeep;
    logic          m_tlast, m_tvalid, m_tready;
    logic [31:0]   pkt_cnt;
    logic          tag_err;

    always #5 axis_clk = ~axis_clk;

    pkt_queue_merge #(.C_S_AXIS_DATA_WIDTH(DW), .C_S_AXIS_TUSER_WIDTH(UW), .C_TAG_DEPTH_BITS(4)) dut (
        .axis_clk(axis_clk), .aresetn(aresetn),
        .qsel_in(qsel_in), .qsel_valid(qsel_valid), .qsel_ready(qsel_ready),
        .s_axis_tdata_0(s_tdata[0]), .s_axis_tuser_0(s_tuser[0]), .s_axis_tkeep_0(s_tkeep[0]),
        .s_axis_tlast_0(s_tlast[0]), .s_axis_tvalid_0(s_tvalid[0]), .s_axis_tready_0(s_tready[0]),
        .s_axis_tdata_1(s_tdata[1]), .s_axis_tuser_1(s_tuser[1]), .s_axis_tkeep_1(s_tkeep[1]),
        .s_axis_tlast_1(s_tlast[1]), .s_axis_tvalid_1(s_tvalid[1]), .s_axis_tready_1(s_tready[1]),
        .s_axis_tdata_2(s_tdata[2]), .s_axis_tuser_2(s_tuser[2]), .s_axis_tkeep_2(s_tkeep[2]),
        .s_axis_tlast_2(s_tlast[2]), .s_axis_tvalid_2(s_tvalid[2]), .s_axis_tready_2(s_tready[2]),
        .s_axis_tdata_3(s_tdata[3]), .s_axis_tuser_3(s_tuser[3]), .s_axis_tkeep_3(s_tkeep[3]),
        .s_axis_tlast_3(s_tlast[3]), .s_axis_tvalid_3(s_tvalid[3]), .s_axis_tready_3(s_tready[3]),
        .m_axis_tdata(m_tdata), .m_axis_tuser(m_tuser), .m_axis_tkeep(m_tkeep),
        .m_axis_tlast(m_tlast), .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready),
        .pkt_cnt(pkt_cnt), .tag_err(tag_err)
    );

    // Model: each queue's beat stream, plus the list of legal tags whose packets are still owed
    beat_t       src_mem [4][SRC_DEPTH];
    int          src_wr [4];
    int          src_rd [4];
    int          mdl_rd [4];
    int          exp_tagq [$];
    logic [31:0] model_cnt;
    bit          gap;
    int          out_beats;
    int          pkt_seq;
    int          n_checks;
    int          n_errors;
    logic [3:0]  pat = 4'b1001;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int tag_idx(input logic [3:0] t);
        for (int i = 0; i < 4; i++) if (t[i]) return i;
        return 0;
    endfunction

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge axis_clk);
            #1;
        end
    endtask

    task automatic push_tag(input logic [3:0] t, output logic acc);
        qsel_in    = t;
        qsel_valid = 1'b1;
        @(negedge axis_clk);
        acc = qsel_ready;
        @(posedge axis_clk);
        #1;
        qsel_valid = 1'b0;
    endtask

    task automatic add_pkt(input int q, input int nb);
        beat_t b;
        for (int i = 0; i < nb; i++) begin
            if (src_wr[q] >= SRC_DEPTH) begin
                $display("FAIL src_overflow: queue %0d full at %0d", q, src_wr[q]);
                $fatal(1);
            end
            b.data = {8'(q), 8'(pkt_seq), 8'(i), 8'hA5, 32'($urandom)};
            b.user = 16'($urandom);
            b.keep = 8'($urandom);
            b.last = (i == nb - 1);
            src_mem[q][src_wr[q]] = b;
            src_wr[q]++;
        end
        pkt_seq++;
    endtask

    task automatic drain(input int max);
        int k = 0;
        while (exp_tagq.size() != 0 && k < max) begin
            cyc(1);
            k++;
        end
        chk("drain_timeout", exp_tagq.size(), 0);
        cyc(2);
    endtask

    task automatic reset_tail();
        cyc(2);
        for (int n = 0; n < 4; n++) begin
            src_rd[n] = src_wr[n];
            mdl_rd[n] = src_wr[n];
        end
        out_beats = 0;
        cyc(1);
        aresetn = 1'b1;
        cyc(2);
    endtask

    task automatic do_reset();
        aresetn = 1'b0;
        reset_tail();
    endtask

    // Source side: presents each queue's next beat and advances on a handshake
    initial begin
        logic [3:0] fire;
        beat_t      b;
        s_tvalid = '0;
        s_tlast  = '0;
        for (int n = 0; n < 4; n++) begin
            s_tdata[n] = '0;
            s_tuser[n] = '0;
            s_tkeep[n] = '0;
        end
        forever begin
            @(negedge axis_clk);
            fire = s_tvalid & s_tready;
            @(posedge axis_clk);
            #1;
            for (int n = 0; n < 4; n++) begin
                if (fire[n]) src_rd[n]++;
                if (src_rd[n] < src_wr[n]) begin
                    b           = src_mem[n][src_rd[n]];
                    s_tvalid[n] = 1'b1;
                    s_tdata[n]  = b.data;
                    s_tuser[n]  = b.user;
                    s_tkeep[n]  = b.keep;
                    s_tlast[n]  = b.last;
                end else begin
                    s_tvalid[n] = 1'b0;
                    s_tlast[n]  = 1'b0;
                end
            end
        end
    end

    // Per-cycle compare against the model
    initial begin
        logic       prev_err;
        logic [3:0] bad;
        beat_t      eb, ob;
        int         q;
        prev_err = 1'b0;
        forever begin
            @(negedge axis_clk);
            if (!aresetn) begin
                chk("rst_tvalid", m_tvalid, 0);
                chk("rst_tready", s_tready, 0);
                chk("rst_qsel_ready", qsel_ready, 0);
                chk("rst_pkt_cnt", pkt_cnt, 0);
                chk("rst_tag_err", tag_err, 0);
                exp_tagq.delete();
                model_cnt = 32'd0;
                gap       = 1'b0;
                prev_err  = 1'b0;
            end else begin
                chk("pkt_cnt", pkt_cnt, model_cnt);
                if (prev_err) chk("tag_err_sticky", tag_err, 1);
                prev_err = tag_err;
                if (gap) chk("gap_tvalid", m_tvalid, 0);
                gap = 1'b0;
                if (exp_tagq.size() == 0) begin
                    chk("idle_tvalid", m_tvalid, 0);
                    chk("idle_tready", s_tready, 0);
                end else begin
                    q   = exp_tagq[0];
                    bad = s_tready & ~(4'b0001 << q);
                    chk("tready_unsel", bad, 0);
                    if (s_tready[q]) chk("tready_mirror", m_tready, 1);
                    if (m_tvalid) begin
                        chk("tready_sel", s_tready[q], m_tready);
                        chk("beat_available", mdl_rd[q] < src_wr[q], 1);
                        if (mdl_rd[q] < src_wr[q]) begin
                            eb = src_mem[q][mdl_rd[q]];
                            ob = {m_tdata, m_tuser, m_tkeep, m_tlast};
                            chk("beat", ob, eb);
                            if (m_tready) begin
                                mdl_rd[q]++;
                                out_beats++;
                                if (eb.last) begin
                                    void'(exp_tagq.pop_front());
                                    model_cnt = model_cnt + 32'd1;
                                    gap       = 1'b1;
                                end
                            end
                        end
                    end
                end
                if (qsel_valid && qsel_ready && $onehot(qsel_in)) exp_tagq.push_back(tag_idx(qsel_in));
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
        $fatal(1);
    end

    initial begin
        logic acc;
        logic seen;
        int   start0;
        n_checks = 0;
        n_errors = 0;
        pkt_seq  = 0;
        out_beats = 0;
        model_cnt = 32'd0;
        for (int n = 0; n < 4; n++) begin
            src_wr[n] = 0;
            src_rd[n] = 0;
            mdl_rd[n] = 0;
        end
        qsel_in    = 4'd0;
        qsel_valid = 1'b0;
        m_tready   = 1'b1;
        #1 aresetn = 1'b0;
        cyc(3);
        aresetn = 1'b1;
        #1;
        chk("qsel_ready_before_clock", qsel_ready, 0);
        cyc(1);
        chk("qsel_ready_after_clock", qsel_ready, 1);
        chk("tag_err_init", tag_err, 0);

        // Two tags, two packets in tag order
        push_tag(4'b0001, acc);
        chk("t1_acc0", acc, 1);
        push_tag(4'b0100, acc);
        chk("t1_acc1", acc, 1);
        add_pkt(0, 3);
        add_pkt(2, 2);
        drain(100);
        chk("t1_pkt_cnt", pkt_cnt, 2);
        chk("t1_beats", out_beats, 5);
        do_reset();

        // Illegal tags are dropped with a sticky error; stray data on q0/q1 must not move
        chk("t2_err_clear", tag_err, 0);
        add_pkt(0, 1);
        add_pkt(1, 1);
        push_tag(4'b0000, acc);
        cyc(3);
        chk("t2_err_zero_tag", tag_err, 1);
        push_tag(4'b0011, acc);
        cyc(3);
        chk("t2_err_multi_tag", tag_err, 1);
        push_tag(4'b1000, acc);
        add_pkt(3, 1);
        drain(100);
        chk("t2_pkt_cnt", pkt_cnt, 1);
        chk("t2_beats", out_beats, 1);
        chk("t2_err_final", tag_err, 1);
        do_reset();

        // Downstream ready toggling 1,0,0,1
        push_tag(4'b0010, acc);
        add_pkt(1, 4);
        for (int i = 0; i < 80 && exp_tagq.size() != 0; i++) begin
            m_tready = pat[i % 4];
            cyc(1);
        end
        m_tready = 1'b1;
        drain(20);
        chk("t3_beats", out_beats, 4);
        chk("t3_pkt_cnt", pkt_cnt, 1);

        // Asynchronous reset during beat 2 of a 4-beat packet
        push_tag(4'b0001, acc);
        start0 = mdl_rd[0];
        add_pkt(0, 4);
        for (int k = 0; k < 50 && mdl_rd[0] - start0 < 1; k++) cyc(1);
        chk("t4_mid_tvalid", m_tvalid, 1);
        #2 aresetn = 1'b0;
        #1;
        chk("t4_async_tvalid", m_tvalid, 0);
        chk("t4_async_tready", s_tready, 0);
        chk("t4_async_qsel_ready", qsel_ready, 0);
        chk("t4_async_pkt_cnt", pkt_cnt, 0);
        chk("t4_async_tag_err", tag_err, 0);
        reset_tail();
        push_tag(4'b1000, acc);
        add_pkt(3, 2);
        drain(100);
        chk("t4_post_pkt_cnt", pkt_cnt, 1);
        chk("t4_post_beats", out_beats, 2);

        // Counter wrap
        force dut.pkt_cnt = 32'hFFFF_FFFF;
        model_cnt = 32'hFFFF_FFFF;
        cyc(1);
        release dut.pkt_cnt;
        cyc(1);
        chk("t5_preload", pkt_cnt, 32'hFFFF_FFFF);
        push_tag(4'b0100, acc);
        add_pkt(2, 1);
        drain(100);
        chk("t5_wrap", pkt_cnt, 0);

        // Tag FIFO full: a blocker parks the FSM on q3 so no tag is popped
        push_tag(4'b1000, acc);
        cyc(3);
        for (int i = 0; i < 16; i++) begin
            push_tag(4'b0001 << (i % 4), acc);
            chk("t6_acc", acc, 1);
        end
        chk("t6_full_ready", qsel_ready, 0);
        push_tag(4'b0001, acc);
        chk("t6_acc17", acc, 0);
        out_beats = 0;
        add_pkt(3, 1);
        for (int i = 0; i < 16; i++) add_pkt(i % 4, 1 + (i % 2));
        drain(600);
        chk("t6_pkt_cnt", pkt_cnt, 17);
        chk("t6_beats", out_beats, 25);
        add_pkt(0, 1);
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            cyc(1);
            seen = seen | m_tvalid;
        end
        chk("t6_no_17th", seen, 0);
        do_reset();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
